// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared character constants and enums for the expression parser
// Ports: none (package). Imported by expr_char_class and expr_eval.
package expr_pkg;

  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  typedef enum logic [1:0] {
    S_OPND,
    S_OPR,
    S_ERR
  } state_t;

  typedef enum logic {
    P_ADD,
    P_MUL
  } pend_t;

  typedef enum logic [1:0] {
    C_DIG,
    C_ADD,
    C_MUL,
    C_BAD
  } char_class_t;

endpackage

// File: rtl/expr_eval_if.sv
// rtl/expr_eval_if.sv - character bus and result bundle for expr_eval
// Signals:
//   restart  synchronous start of a new expression (master -> slave)
//   in       ASCII character                      (master -> slave)
//   in_vld   character strobe                     (master -> slave)
//   val      value of last complete prefix        (slave -> master)
//   val_ok   stream is a complete expression      (slave -> master)
//   err      sticky syntax error                  (slave -> master)
//   ovf      sticky arithmetic overflow           (slave -> master)
interface expr_eval_if #(
  parameter int W = 16
);

  logic         restart;
  logic [7:0]   in;
  logic         in_vld;
  logic [W-1:0] val;
  logic         val_ok;
  logic         err;
  logic         ovf;

  modport master (
    output restart, in, in_vld,
    input  val, val_ok, err, ovf
  );

  modport slave (
    input  restart, in, in_vld,
    output val, val_ok, err, ovf
  );

endinterface

// File: rtl/expr_char_class.sv
// rtl/expr_char_class.sv - combinational ASCII classifier for the expression stream
// Ports:
//   in     [7:0] ASCII character
//   cls          character class (C_DIG / C_ADD / C_MUL / C_BAD)
//   digit  [3:0] digit value, 0 when not a digit
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0]  in,
  output char_class_t cls,
  output logic [3:0]  digit
);

  always_comb begin
    cls   = C_BAD;
    digit = 4'd0;
    if (in >= CH_0 && in <= CH_9) begin
      cls   = C_DIG;
      // '0'..'9' are 8'h30..8'h39, so the low nibble is already the value.
      digit = in[3:0];
    end else if (in == CH_PLUS) begin
      cls = C_ADD;
    end else if (in == CH_STAR) begin
      cls = C_MUL;
    end
  end

endmodule

// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - streaming evaluator for single-digit '+'/'*' expressions
// Ports:
//   clk    clock, rising edge
//   clr_n  asynchronous active-low reset
//   bus    expr_eval_if slave: restart/in/in_vld in, val/val_ok/err/ovf out
module expr_eval
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        clr_n,
  expr_eval_if.slave  bus
);

  state_t      st, st_n;
  pend_t       pend, pend_n;
  logic [W-1:0] sum, sum_n;
  logic [W-1:0] prod, prod_n;
  logic [W-1:0] val_q, val_n;
  logic        val_ok_q, val_ok_n;
  logic        err_q, err_n;
  logic        ovf_q, ovf_n;

  char_class_t cls;
  logic [3:0]  digit;

  expr_char_class u_cls (
    .in    (bus.in),
    .cls   (cls),
    .digit (digit)
  );

  // Datapath: W x 4 multiplier, sum + new product, sum + current product.
  logic [W+3:0] mul_full;
  logic         mul_hi;
  logic [W-1:0] new_prod;
  logic [W:0]   sum_new;
  logic [W:0]   sum_pp;

  assign mul_full = {4'b0000, prod} * {{W{1'b0}}, digit};
  // The multiplier only counts as overflowing when its result is actually used.
  assign mul_hi   = (pend == P_MUL) && (|mul_full[W+3:W]);
  assign new_prod = (pend == P_MUL) ? mul_full[W-1:0] : W'(digit);
  assign sum_new  = {1'b0, sum} + {1'b0, new_prod};
  assign sum_pp   = {1'b0, sum} + {1'b0, prod};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      st       <= S_OPND;
      pend     <= P_ADD;
      sum      <= '0;
      prod     <= '0;
      val_q    <= '0;
      val_ok_q <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      st       <= st_n;
      pend     <= pend_n;
      sum      <= sum_n;
      prod     <= prod_n;
      val_q    <= val_n;
      val_ok_q <= val_ok_n;
      err_q    <= err_n;
      ovf_q    <= ovf_n;
    end
  end

  always_comb begin
    st_n     = st;
    pend_n   = pend;
    sum_n    = sum;
    prod_n   = prod;
    val_n    = val_q;
    val_ok_n = val_ok_q;
    err_n    = err_q;
    ovf_n    = ovf_q;

    // restart wins over a character strobed on the same edge.
    if (bus.restart) begin
      st_n     = S_OPND;
      pend_n   = P_ADD;
      sum_n    = '0;
      prod_n   = '0;
      val_n    = '0;
      val_ok_n = 1'b0;
      err_n    = 1'b0;
      ovf_n    = 1'b0;
    end else if (bus.in_vld) begin
      case (st)
        S_OPND: begin
          if (cls == C_DIG) begin
            prod_n   = new_prod;
            val_n    = sum_new[W-1:0];
            val_ok_n = 1'b1;
            st_n     = S_OPR;
            if (mul_hi || sum_new[W]) ovf_n = 1'b1;
          end else begin
            st_n     = S_ERR;
            err_n    = 1'b1;
            val_ok_n = 1'b0;
          end
        end
        S_OPR: begin
          if (cls == C_ADD) begin
            sum_n    = sum_pp[W-1:0];
            pend_n   = P_ADD;
            val_ok_n = 1'b0;
            st_n     = S_OPND;
            if (sum_pp[W]) ovf_n = 1'b1;
          end else if (cls == C_MUL) begin
            pend_n   = P_MUL;
            val_ok_n = 1'b0;
            st_n     = S_OPND;
          end else begin
            st_n     = S_ERR;
            err_n    = 1'b1;
            val_ok_n = 1'b0;
          end
        end
        default: begin
          // S_ERR absorbs everything until restart or reset.
          st_n = S_ERR;
        end
      endcase
    end
  end

  assign bus.val    = val_q;
  assign bus.val_ok = val_ok_q;
  assign bus.err    = err_q;
  assign bus.ovf    = ovf_q;

endmodule
